// File: rtl/nco2_phase_sched.sv
// Phase scheduler for the dual-slot time-multiplexed NCO.
// Drives the slot toggle, the double-buffered phi0/phi1 increments with an
// optional per-slot linear sweep, and a one-frame NCO phase reset.
// Ports:
//   clk, rst               NCO 2x clock, async active-high reset
//   cfg_valid/ready/addr/data  host shadow-register write channel
//   commit / commit_ack    request shadow->active transfer / apply pulse
//   sync_req / sync_busy   request NCO phase reset / reset pending or active
//   state, frame_start     slot select and first-cycle-of-frame flag
//   phi0, phi1             active slot increments
//   nco_rst                phase reset to the NCO
module nco2_phase_sched #(
  parameter int unsigned PHI_W    = 32,
  parameter bit          SWEEP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [PHI_W-1:0] cfg_data,
  input  logic             commit,
  output logic             commit_ack,
  input  logic             sync_req,
  output logic             sync_busy,
  output logic             state,
  output logic [PHI_W-1:0] phi0,
  output logic [PHI_W-1:0] phi1,
  output logic             nco_rst,
  output logic             frame_start
);

  typedef enum logic [1:0] {
    SYNC_IDLE = 2'd0,
    SYNC_PEND = 2'd1,
    SYNC_RST  = 2'd2
  } sync_st_t;

  // Shadow (host-visible) and active sweep configuration
  logic [PHI_W-1:0] phi0_sh, phi1_sh, step0_sh, step1_sh;
  logic [1:0]       ctrl_sh;
  logic [PHI_W-1:0] step0, step1;
  logic [1:0]       sweep_en;
  logic             commit_pending;

  // Combinational helpers
  logic             boundary, wr_en, apply, pend_nxt;
  logic             wr_phi0, wr_phi1, wr_step0, wr_step1, wr_ctrl;
  logic [PHI_W-1:0] phi0_new, phi1_new, step0_new, step1_new;
  logic [1:0]       ctrl_new;

  sync_st_t sync_st, sync_nxt;

  // Write decode, commit apply and write-bypass selection
  always_comb begin
    boundary  = state;
    wr_en     = cfg_valid & cfg_ready;
    wr_phi0   = wr_en && (cfg_addr == 3'd0);
    wr_phi1   = wr_en && (cfg_addr == 3'd1);
    wr_step0  = wr_en && (cfg_addr == 3'd2);
    wr_step1  = wr_en && (cfg_addr == 3'd3);
    wr_ctrl   = wr_en && (cfg_addr == 3'd4);
    apply     = boundary & (commit_pending | commit);
    pend_nxt  = (commit_pending | commit) & ~boundary;
    // A write landing on the applying edge is folded into the committed set
    phi0_new  = wr_phi0  ? cfg_data : phi0_sh;
    phi1_new  = wr_phi1  ? cfg_data : phi1_sh;
    step0_new = wr_step0 ? cfg_data : step0_sh;
    step1_new = wr_step1 ? cfg_data : step1_sh;
    ctrl_new  = wr_ctrl  ? cfg_data[1:0] : ctrl_sh;
    if (!SWEEP_EN) begin
      ctrl_new = 2'b00;
    end
  end

  // Slot toggle, frame flag and write-channel handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= 1'b0;
      frame_start    <= 1'b1;
      commit_pending <= 1'b0;
      cfg_ready      <= 1'b1;
      commit_ack     <= 1'b0;
    end else begin
      state          <= ~state;
      frame_start    <= state;
      commit_pending <= pend_nxt;
      cfg_ready      <= ~pend_nxt | ~state;
      commit_ack     <= apply;
    end
  end

  // Shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi0_sh  <= '0;
      phi1_sh  <= '0;
      step0_sh <= '0;
      step1_sh <= '0;
      ctrl_sh  <= 2'b00;
    end else begin
      phi0_sh  <= phi0_new;
      phi1_sh  <= phi1_new;
      step0_sh <= step0_new;
      step1_sh <= step1_new;
      ctrl_sh  <= ctrl_new;
    end
  end

  // Active registers: commit wins over sweep on the same boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi0     <= '0;
      phi1     <= '0;
      step0    <= '0;
      step1    <= '0;
      sweep_en <= 2'b00;
    end else if (apply) begin
      phi0     <= phi0_new;
      phi1     <= phi1_new;
      step0    <= step0_new;
      step1    <= step1_new;
      sweep_en <= ctrl_new;
    end else if (boundary) begin
      if (sweep_en[0]) begin
        phi0 <= phi0 + step0;
      end
      if (sweep_en[1]) begin
        phi1 <= phi1 + step1;
      end
    end
  end

  // Sync sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_st <= SYNC_IDLE;
    end else begin
      sync_st <= sync_nxt;
    end
  end

  // Sync sequencer next state: wait for a boundary, then hold reset one frame
  always_comb begin
    sync_nxt = sync_st;
    case (sync_st)
      SYNC_IDLE: if (sync_req) sync_nxt = SYNC_PEND;
      SYNC_PEND: if (boundary) sync_nxt = SYNC_RST;
      SYNC_RST:  if (boundary) sync_nxt = SYNC_IDLE;
      default:   sync_nxt = SYNC_IDLE;
    endcase
  end

  // Registered sync outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nco_rst   <= 1'b0;
      sync_busy <= 1'b0;
    end else begin
      nco_rst   <= (sync_nxt == SYNC_RST);
      sync_busy <= (sync_nxt != SYNC_IDLE);
    end
  end

endmodule
